// File: rtl/adt_pkg.sv
// Shared state encoding, default sensor limits and small helpers for the ADT poll scheduler.
package adt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_CFG,
        ST_WAIT_TMR,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_REQ,
        ST_WR_WAIT,
        ST_FAULT
    } adt_state_e;

    // Temperatures are signed, 1/128 C per LSB.
    localparam logic [23:0] ADT_POLL_CNT = 24'd1000000;
    localparam logic [15:0] ADT_TMO_CNT  = 16'd50000;
    localparam logic [15:0] ADT_HI_LIM   = 16'h3200;
    localparam logic [15:0] ADT_LO_LIM   = 16'hEC00;
    localparam logic [15:0] ADT_HYST     = 16'h0100;
    localparam logic [3:0]  ADT_ERR_MAX  = 4'd3;

    localparam int VLD_STAGES = 1;

    typedef struct packed {
        logic        dval;
        logic [15:0] dvalue;
        logic        wr_done;
        logic        chip_err;
    } adt_rsp_t;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/adt_alarm_hyst.sv
// One temperature alarm with hysteresis; HI selects an over-limit or under-limit alarm.
module adt_alarm_hyst
    import adt_pkg::*;
#(
    parameter logic [15:0] LIM  = ADT_HI_LIM,
    parameter logic [15:0] HYST = ADT_HYST,
    parameter bit          HI   = 1'b1
) (
    input  logic        clk_sys,
    input  logic        rst_sys_n,
    input  logic        upd,
    input  logic [15:0] value,
    output logic        alm
);

    // 17 bits so LIM +/- HYST cannot wrap near the 16-bit extremes
    logic signed [16:0] v_s, lim_s, hyst_s, rel_s;
    logic               set_c, clr_c;

    assign v_s    = {value[15], value};
    assign lim_s  = {LIM[15], LIM};
    assign hyst_s = {1'b0, HYST};
    assign rel_s  = HI ? (lim_s - hyst_s) : (lim_s + hyst_s);
    assign set_c  = HI ? (v_s > lim_s)  : (v_s < lim_s);
    assign clr_c  = HI ? (v_s <= rel_s) : (v_s >= rel_s);

    always_ff @(posedge clk_sys) begin
        if (!rst_sys_n) begin
            alm <= 1'b0;
        end else if (upd) begin
            if (set_c)      alm <= 1'b1;
            else if (clr_c) alm <= 1'b0;
        end
    end

endmodule

// File: rtl/adt_poll_sched.sv
// Periodic temperature poll scheduler for the ADT sensor controller with host writes,
// response timeouts, consecutive-error fault handling and hysteretic alarms.
module adt_poll_sched
    import adt_pkg::*;
#(
    parameter logic [23:0] POLL_CNT = ADT_POLL_CNT,
    parameter logic [15:0] TMO_CNT  = ADT_TMO_CNT,
    parameter logic [15:0] HI_LIM   = ADT_HI_LIM,
    parameter logic [15:0] LO_LIM   = ADT_LO_LIM,
    parameter logic [15:0] HYST     = ADT_HYST,
    parameter logic [3:0]  ERR_MAX  = ADT_ERR_MAX
) (
    input  logic        clk_sys,
    input  logic        rst_sys_n,
    input  logic        sched_en,
    input  logic        host_wr_req,
    input  logic [15:0] host_wr_value,
    output logic        host_wr_ack,
    output logic        adt_pw_on_en,
    output logic        adt_wr_en,
    output logic        adt_rd_en,
    output logic [15:0] adt_wr_value,
    input  logic        adt_rd_dval,
    input  logic [15:0] adt_rd_dvalue,
    input  logic        adt_spi_busy,
    input  logic        adt_con_done,
    input  logic        adt_wr_done,
    input  logic        adt_chip_err,
    output logic [15:0] temp_value,
    output logic        temp_vld,
    output logic        temp_hi_alm,
    output logic        temp_lo_alm,
    output logic        comm_err,
    output logic [3:0]  err_cnt
);

    adt_state_e          state;
    adt_rsp_t            rsp;
    logic [23:0]         poll_tmr;
    logic                poll_pend;
    logic [15:0]         wait_cnt;
    logic                wr_pend;
    logic                wr_rearm;
    logic [15:0]         wr_value;
    logic [VLD_STAGES:0] vld_pipe;

    logic                poll_run, poll_wrap, waiting, tmo_hit;
    logic                wr_launch, wr_busy, err_trip;
    logic [3:0]          err_inc;

    assign rsp = '{dval: adt_rd_dval, dvalue: adt_rd_dvalue,
                   wr_done: adt_wr_done, chip_err: adt_chip_err};

    assign poll_run  = (state != ST_IDLE) && (state != ST_WAIT_CFG) && (state != ST_FAULT);
    assign poll_wrap = poll_run && (poll_tmr == POLL_CNT - 24'd1);
    assign waiting   = (state == ST_WAIT_CFG) || (state == ST_RD_WAIT) || (state == ST_WR_WAIT);
    assign tmo_hit   = (wait_cnt == TMO_CNT - 16'd1);
    assign err_inc   = sat_inc4(err_cnt);
    assign err_trip  = (err_inc >= ERR_MAX);

    // A host request that lands while a write is in flight must survive that write's ack.
    assign wr_launch = (state == ST_WAIT_TMR) && !adt_spi_busy && wr_pend;
    assign wr_busy   = wr_launch || (state == ST_WR_REQ) || (state == ST_WR_WAIT);

    assign temp_vld  = vld_pipe[VLD_STAGES];

    always_ff @(posedge clk_sys) begin
        if (!rst_sys_n) begin
            state        <= ST_IDLE;
            poll_tmr     <= '0;
            poll_pend    <= 1'b0;
            wait_cnt     <= '0;
            wr_pend      <= 1'b0;
            wr_rearm     <= 1'b0;
            wr_value     <= '0;
            vld_pipe     <= '0;
            temp_value   <= '0;
            err_cnt      <= '0;
            comm_err     <= 1'b0;
            adt_pw_on_en <= 1'b0;
            adt_wr_en    <= 1'b0;
            adt_rd_en    <= 1'b0;
            adt_wr_value <= '0;
            host_wr_ack  <= 1'b0;
        end else begin
            adt_rd_en   <= 1'b0;
            adt_wr_en   <= 1'b0;
            host_wr_ack <= 1'b0;
            vld_pipe    <= {vld_pipe[VLD_STAGES-1:0], 1'b0};

            if (!sched_en && state != ST_IDLE) begin
                state        <= ST_IDLE;
                adt_pw_on_en <= 1'b0;
                comm_err     <= 1'b0;
                poll_tmr     <= '0;
                poll_pend    <= 1'b0;
                wait_cnt     <= '0;
                wr_pend      <= 1'b0;
                wr_rearm     <= 1'b0;
            end else begin
                wait_cnt <= waiting ? wait_cnt + 16'd1 : '0;

                case (state)
                    ST_IDLE: begin
                        if (sched_en) begin
                            state        <= ST_WAIT_CFG;
                            adt_pw_on_en <= 1'b1;
                            err_cnt      <= '0;
                        end
                    end
                    ST_WAIT_CFG: begin
                        if (adt_con_done) begin
                            state <= ST_WAIT_TMR;
                        end else if (tmo_hit) begin
                            state    <= ST_FAULT;
                            comm_err <= 1'b1;
                        end
                    end
                    ST_WAIT_TMR: begin
                        if (wr_launch) begin
                            state        <= ST_WR_REQ;
                            adt_wr_en    <= 1'b1;
                            adt_wr_value <= wr_value;
                            wr_rearm     <= 1'b0;
                        end else if (!adt_spi_busy && poll_pend) begin
                            state     <= ST_RD_REQ;
                            adt_rd_en <= 1'b1;
                            poll_pend <= 1'b0;
                        end
                    end
                    ST_RD_REQ: state <= ST_RD_WAIT;
                    ST_WR_REQ: state <= ST_WR_WAIT;
                    ST_RD_WAIT: begin
                        // a reading arriving on the timeout cycle still counts as good
                        if (rsp.dval) begin
                            temp_value  <= rsp.dvalue;
                            vld_pipe[0] <= 1'b1;
                            err_cnt     <= '0;
                            state       <= ST_WAIT_TMR;
                        end else if (tmo_hit || rsp.chip_err) begin
                            err_cnt  <= err_inc;
                            state    <= err_trip ? ST_FAULT : ST_WAIT_TMR;
                            comm_err <= err_trip;
                        end
                    end
                    ST_WR_WAIT: begin
                        if (rsp.wr_done) begin
                            host_wr_ack <= 1'b1;
                            wr_pend     <= wr_rearm;
                            err_cnt     <= '0;
                            state       <= ST_WAIT_TMR;
                        end else if (tmo_hit || rsp.chip_err) begin
                            err_cnt  <= err_inc;
                            state    <= err_trip ? ST_FAULT : ST_WAIT_TMR;
                            comm_err <= err_trip;
                        end
                    end
                    ST_FAULT: state <= ST_FAULT;
                    default:  state <= ST_IDLE;
                endcase

                // placed after the FSM so a wrap on the RD_REQ entry cycle is not lost
                if (poll_run) begin
                    if (poll_wrap) begin
                        poll_tmr  <= '0;
                        poll_pend <= 1'b1;
                    end else begin
                        poll_tmr <= poll_tmr + 24'd1;
                    end
                end else begin
                    poll_tmr <= '0;
                end
            end

            if (host_wr_req) begin
                wr_pend  <= 1'b1;
                wr_value <= host_wr_value;
                if (wr_busy) wr_rearm <= 1'b1;
            end
        end
    end

    adt_alarm_hyst #(
        .LIM  (HI_LIM),
        .HYST (HYST),
        .HI   (1'b1)
    ) u_alm_hi (
        .clk_sys   (clk_sys),
        .rst_sys_n (rst_sys_n),
        .upd       (vld_pipe[0]),
        .value     (temp_value),
        .alm       (temp_hi_alm)
    );

    adt_alarm_hyst #(
        .LIM  (LO_LIM),
        .HYST (HYST),
        .HI   (1'b0)
    ) u_alm_lo (
        .clk_sys   (clk_sys),
        .rst_sys_n (rst_sys_n),
        .upd       (vld_pipe[0]),
        .value     (temp_value),
        .alm       (temp_lo_alm)
    );

endmodule

// File: tb/tb_adt_poll_sched.sv
// Directed bench for adt_poll_sched with shortened poll/timeout periods.
module tb_adt_poll_sched;

    logic        clk_sys = 1'b0;
    logic        rst_sys_n = 1'b0;
    logic        sched_en = 1'b0;
    logic        host_wr_req = 1'b0;
    logic [15:0] host_wr_value = '0;
    logic        host_wr_ack;
    logic        adt_pw_on_en;
    logic        adt_wr_en;
    logic        adt_rd_en;
    logic [15:0] adt_wr_value;
    logic        adt_rd_dval = 1'b0;
    logic [15:0] adt_rd_dvalue = '0;
    logic        adt_spi_busy = 1'b0;
    logic        adt_con_done = 1'b0;
    logic        adt_wr_done = 1'b0;
    logic        adt_chip_err = 1'b0;
    logic [15:0] temp_value;
    logic        temp_vld;
    logic        temp_hi_alm;
    logic        temp_lo_alm;
    logic        comm_err;
    logic [3:0]  err_cnt;

    adt_poll_sched #(
        .POLL_CNT (24'd100),
        .TMO_CNT  (16'd50),
        .ERR_MAX  (4'd3)
    ) dut (
        .clk_sys       (clk_sys),
        .rst_sys_n     (rst_sys_n),
        .sched_en      (sched_en),
        .host_wr_req   (host_wr_req),
        .host_wr_value (host_wr_value),
        .host_wr_ack   (host_wr_ack),
        .adt_pw_on_en  (adt_pw_on_en),
        .adt_wr_en     (adt_wr_en),
        .adt_rd_en     (adt_rd_en),
        .adt_wr_value  (adt_wr_value),
        .adt_rd_dval   (adt_rd_dval),
        .adt_rd_dvalue (adt_rd_dvalue),
        .adt_spi_busy  (adt_spi_busy),
        .adt_con_done  (adt_con_done),
        .adt_wr_done   (adt_wr_done),
        .adt_chip_err  (adt_chip_err),
        .temp_value    (temp_value),
        .temp_vld      (temp_vld),
        .temp_hi_alm   (temp_hi_alm),
        .temp_lo_alm   (temp_lo_alm),
        .comm_err      (comm_err),
        .err_cnt       (err_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    int n_cmp = 0;
    int n_bad = 0;
    int vld_seen = 0;

    always @(posedge clk_sys) if (temp_vld === 1'b1) vld_seen <= vld_seen + 1;

    typedef struct {
        logic [15:0] val;
        logic        hi;
        logic        lo;
    } alm_vec_t;

    alm_vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    function automatic logic sig_sel(input int which);
        case (which)
            0:       return adt_rd_en;
            1:       return adt_wr_en;
            2:       return host_wr_ack;
            default: return temp_vld;
        endcase
    endfunction

    task automatic wait_sig(input int which, input int budget, input string name, output int cyc);
        cyc = 0;
        while (sig_sel(which) !== 1'b1 && cyc < budget) begin
            @(negedge clk_sys);
            cyc++;
        end
        chk(name, {31'd0, sig_sel(which)}, 32'd1);
    endtask

    task automatic do_read(input logic [15:0] val, input string name);
        int cyc;
        wait_sig(0, 250, name, cyc);
        tick(2);
        adt_rd_dval   = 1'b1;
        adt_rd_dvalue = val;
        tick(1);
        adt_rd_dval   = 1'b0;
        wait_sig(3, 5, name, cyc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int v0;
        int strobes;

        vecs[0]  = '{16'h0C80, 1'b0, 1'b0};
        vecs[1]  = '{16'h3300, 1'b1, 1'b0};
        vecs[2]  = '{16'h3180, 1'b1, 1'b0};
        vecs[3]  = '{16'h30FF, 1'b0, 1'b0};
        vecs[4]  = '{16'h3200, 1'b0, 1'b0};
        vecs[5]  = '{16'h3201, 1'b1, 1'b0};
        vecs[6]  = '{16'h3100, 1'b0, 1'b0};
        vecs[7]  = '{16'hEB00, 1'b0, 1'b1};
        vecs[8]  = '{16'hEC80, 1'b0, 1'b1};
        vecs[9]  = '{16'hED00, 1'b0, 1'b0};
        vecs[10] = '{16'hEC00, 1'b0, 1'b0};
        vecs[11] = '{16'hEBFF, 1'b0, 1'b1};
        vecs[12] = '{16'h0000, 1'b0, 1'b0};

        // reset state
        tick(3);
        chk("rst_flags", {adt_pw_on_en, adt_rd_en, adt_wr_en, host_wr_ack,
                          temp_vld, temp_hi_alm, temp_lo_alm, comm_err}, 32'd0);
        chk("rst_temp", temp_value, 32'd0);
        chk("rst_err_cnt", err_cnt, 32'd0);
        chk("rst_wr_value", adt_wr_value, 32'd0);

        // enable, config done, first poll read
        rst_sys_n = 1'b1;
        sched_en  = 1'b1;
        tick(1);
        chk("pw_on_after_en", adt_pw_on_en, 32'd1);
        tick(9);
        adt_con_done = 1'b1;
        tick(1);
        adt_con_done = 1'b0;
        wait_sig(0, 200, "first_rd_en", cyc);
        chk("first_rd_latency", (cyc >= 95 && cyc <= 110), 32'd1);
        tick(1);
        chk("rd_en_one_cycle", adt_rd_en, 32'd0);
        tick(1);
        v0 = vld_seen;
        adt_rd_dval   = 1'b1;
        adt_rd_dvalue = 16'h0C80;
        tick(1);
        adt_rd_dval   = 1'b0;
        wait_sig(3, 5, "first_temp_vld", cyc);
        chk("first_temp_value", temp_value, 32'h0C80);
        tick(3);
        chk("first_vld_pulses", vld_seen - v0, 32'd1);
        chk("first_err_cnt", err_cnt, 32'd0);

        // write and poll both pending: write goes first
        adt_spi_busy  = 1'b1;
        host_wr_req   = 1'b1;
        host_wr_value = 16'h5420;
        tick(1);
        host_wr_req   = 1'b0;
        strobes = 0;
        for (int i = 0; i < 130; i++) begin
            @(negedge clk_sys);
            if (adt_rd_en || adt_wr_en) strobes++;
        end
        chk("busy_blocks_strobes", strobes, 32'd0);
        adt_spi_busy = 1'b0;
        cyc = 0;
        while (!adt_wr_en && !adt_rd_en && cyc < 10) begin
            @(negedge clk_sys);
            cyc++;
        end
        chk("wr_first_wr_en", adt_wr_en, 32'd1);
        chk("wr_first_rd_en", adt_rd_en, 32'd0);
        chk("wr_value", adt_wr_value, 32'h5420);
        tick(2);
        adt_wr_done = 1'b1;
        tick(1);
        adt_wr_done = 1'b0;
        wait_sig(2, 5, "host_wr_ack", cyc);
        wait_sig(0, 10, "rd_after_wr", cyc);
        tick(2);
        adt_rd_dval   = 1'b1;
        adt_rd_dvalue = 16'h0C80;
        tick(1);
        adt_rd_dval   = 1'b0;
        wait_sig(3, 5, "rd_after_wr_vld", cyc);

        // alarm hysteresis table
        for (int i = 0; i < 13; i++) begin
            do_read(vecs[i].val, $sformatf("alm_read_%0d", i));
            chk($sformatf("alm_temp_%0d", i), temp_value, {16'd0, vecs[i].val});
            chk($sformatf("alm_hi_%0d", i), temp_hi_alm, {31'd0, vecs[i].hi});
            chk($sformatf("alm_lo_%0d", i), temp_lo_alm, {31'd0, vecs[i].lo});
        end

        // timeout lands exactly TMO_CNT cycles into RD_WAIT
        wait_sig(0, 250, "tmo_rd_en", cyc);
        tick(50);
        chk("tmo_not_early", err_cnt, 32'd0);
        tick(1);
        chk("tmo_at_limit", err_cnt, 32'd1);

        // data valid on the timeout cycle wins
        wait_sig(0, 250, "race_rd_en", cyc);
        tick(50);
        adt_rd_dval   = 1'b1;
        adt_rd_dvalue = 16'h0A00;
        tick(1);
        adt_rd_dval   = 1'b0;
        chk("race_err_cnt", err_cnt, 32'd0);
        chk("race_temp", temp_value, 32'h0A00);
        wait_sig(3, 5, "race_vld", cyc);

        // three silent reads -> FAULT
        for (int i = 1; i <= 3; i++) begin
            wait_sig(0, 250, $sformatf("err_rd_en_%0d", i), cyc);
            tick(55);
            chk($sformatf("err_cnt_%0d", i), err_cnt, i);
            chk($sformatf("comm_err_%0d", i), comm_err, (i == 3) ? 32'd1 : 32'd0);
        end
        chk("fault_pw_on", adt_pw_on_en, 32'd1);
        strobes = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk_sys);
            if (adt_rd_en || adt_wr_en) strobes++;
        end
        chk("fault_no_strobes", strobes, 32'd0);
        chk("fault_holds", comm_err, 32'd1);
        sched_en = 1'b0;
        tick(1);
        chk("fault_exit_comm_err", comm_err, 32'd0);
        chk("fault_exit_pw_on", adt_pw_on_en, 32'd0);
        chk("fault_exit_temp_kept", temp_value, 32'h0A00);

        // no config done -> FAULT
        sched_en = 1'b1;
        tick(1);
        chk("cfg_pw_on", adt_pw_on_en, 32'd1);
        tick(55);
        chk("cfg_tmo_fault", comm_err, 32'd1);
        sched_en = 1'b0;
        tick(1);
        chk("cfg_exit", comm_err, 32'd0);

        // reset during RD_WAIT
        sched_en = 1'b1;
        tick(2);
        adt_con_done = 1'b1;
        tick(1);
        adt_con_done = 1'b0;
        wait_sig(0, 250, "rst_rd_en", cyc);
        tick(2);
        v0 = vld_seen;
        rst_sys_n = 1'b0;
        sched_en  = 1'b0;
        tick(1);
        adt_rd_dval   = 1'b1;
        adt_rd_dvalue = 16'h1234;
        tick(1);
        adt_rd_dval   = 1'b0;
        tick(1);
        rst_sys_n = 1'b1;
        tick(5);
        chk("midrst_flags", {adt_pw_on_en, adt_rd_en, adt_wr_en, host_wr_ack,
                             temp_vld, temp_hi_alm, temp_lo_alm, comm_err}, 32'd0);
        chk("midrst_temp", temp_value, 32'd0);
        chk("midrst_err_cnt", err_cnt, 32'd0);
        chk("midrst_wr_value", adt_wr_value, 32'd0);
        chk("midrst_no_vld", vld_seen - v0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
